// File: rtl/tb_cmd_sched_pkg.sv
// Shared types for the testbench command scheduler: opcodes, completion
// status codes, FSM states and the resource count.
package tb_cmd_sched_pkg;

  localparam int unsigned NUM_RES = 4;

  typedef enum logic [2:0] {
    OP_NOP           = 3'd0,
    OP_SET           = 3'd1,
    OP_WAIT_EVENT    = 3'd2,
    OP_CHECK         = 3'd3,
    OP_WAIT_DURATION = 3'd4
  } t_cmd_op;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_TIMEOUT   = 2'd1,
    ST_CHECK_ERR = 2'd2,
    ST_BAD_OP    = 2'd3
  } t_cmd_status;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } t_sched_state;

endpackage

// File: rtl/tb_timeout_cnt.sv
// Per-command timeout down-counter. Built only when TB_CMD_SCHED_TIMEOUT_EN
// is defined. expired pulses in the enabled cycle where the count goes 1->0;
// a loaded value of 0 never expires.
`ifdef TB_CMD_SCHED_TIMEOUT_EN
module tb_timeout_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;

  // Load on issue, then count down towards zero while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired = en && (cnt_q == WIDTH'(1));

endmodule
`endif

// File: rtl/tb_cmd_scheduler.sv
// Testbench command scheduler: accepts one decoded command at a time, selects
// one resource, waits for its done strobe (or an optional timeout) and
// returns a one-cycle completion with status. Optional timeout support is
// compiled in with TB_CMD_SCHED_TIMEOUT_EN.
module tb_cmd_scheduler
  import tb_cmd_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_WIDTH = 32,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  input  logic [2:0]               i_cmd_op,
  input  logic [TIMEOUT_WIDTH-1:0] i_cmd_timeout,
  output logic                     o_cmd_ready,
  output logic                     o_sel_set,
  output logic                     o_sel_wait,
  output logic                     o_sel_check,
  output logic                     o_sel_wait_duration,
  output logic                     o_args_valid,
  input  logic                     i_set_done,
  input  logic                     i_wait_done,
  input  logic                     i_check_done,
  input  logic                     i_wait_duration_done,
  input  logic                     i_check_err,
  output logic                     o_cmd_done,
  output logic [1:0]               o_cmd_status,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  t_sched_state             state_q, state_d;
  t_cmd_status              resp_status, status_q;
  logic [2:0]               op_q;
  logic [NUM_RES-1:0]       res_sel, res_done;
  logic                     sel_done, timeout_hit;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  // One-hot resource decode of the latched opcode; bit order set, wait, check, duration.
  always_comb begin
    res_sel = '0;
    case (op_q)
      OP_SET:           res_sel[0] = 1'b1;
      OP_WAIT_EVENT:    res_sel[1] = 1'b1;
      OP_CHECK:         res_sel[2] = 1'b1;
      OP_WAIT_DURATION: res_sel[3] = 1'b1;
      default:          res_sel    = '0;
    endcase
  end

  assign res_done = {i_wait_duration_done, i_check_done, i_wait_done, i_set_done};
  assign sel_done = |(res_sel & res_done);

  // Latch the opcode of an accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
    end else if ((state_q == S_IDLE) && i_cmd_valid) begin
      op_q <= i_cmd_op;
    end
  end

`ifdef TB_CMD_SCHED_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] timeout_q;
  logic                     cnt_load, cnt_en;

  // Latch the timeout of an accepted command; the counter picks it up in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= '0;
    end else if ((state_q == S_IDLE) && i_cmd_valid) begin
      timeout_q <= i_cmd_timeout;
    end
  end

  assign cnt_load = (state_q == S_ISSUE);
  assign cnt_en   = (state_q == S_BUSY);

  tb_timeout_cnt #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (timeout_q),
    .en       (cnt_en),
    .expired  (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^i_cmd_timeout;
  assign timeout_hit    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and completion status; a done strobe outranks a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    resp_status = ST_OK;
    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd_op)
            OP_SET, OP_WAIT_EVENT, OP_CHECK, OP_WAIT_DURATION: state_d = S_ISSUE;
            OP_NOP: begin
              state_d     = S_RESP;
              resp_status = ST_OK;
            end
            default: begin
              state_d     = S_RESP;
              resp_status = ST_BAD_OP;
            end
          endcase
        end
      end
      S_ISSUE: state_d = S_BUSY;
      S_BUSY: begin
        if (sel_done) begin
          state_d = S_RESP;
          if ((op_q == OP_CHECK) && i_check_err) begin
            resp_status = ST_CHECK_ERR;
          end
        end else if (timeout_hit) begin
          state_d     = S_RESP;
          resp_status = ST_TIMEOUT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture status and bump the saturating error count as RESP is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q  <= ST_OK;
      err_cnt_q <= '0;
    end else if (state_d == S_RESP) begin
      status_q <= resp_status;
      if ((resp_status != ST_OK) && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    o_cmd_ready  = (state_q == S_IDLE);
    o_args_valid = (state_q == S_ISSUE);
    o_cmd_done   = (state_q == S_RESP);
    {o_sel_wait_duration, o_sel_check, o_sel_wait, o_sel_set} =
      ((state_q == S_ISSUE) || (state_q == S_BUSY)) ? res_sel : '0;
    o_cmd_status = status_q;
    o_err_cnt    = err_cnt_q;
  end

endmodule

// File: tb/tb_tb_cmd_scheduler.sv
// Self-checking bench for tb_cmd_scheduler: directed vector table, hand
// sequences for back-to-back, reset and saturation, then random commands
// against a transaction-level latency/status model.
module tb_tb_cmd_scheduler;

`ifdef TB_CMD_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int ERR_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_timeout;
  logic        set_done, wait_done, check_done, wd_done, check_err;
  logic        o_cmd_ready, o_sel_set, o_sel_wait, o_sel_check, o_sel_wait_duration;
  logic        o_args_valid, o_cmd_done;
  logic [1:0]  o_cmd_status;
  logic [1:0]  o_err_cnt;

  int          checks = 0;
  int          errors = 0;
  int          err_model = 0;
  logic [1:0]  last_st = 2'd0;
  int unsigned cyc = 0;
  int unsigned last_done_cyc = 0;

  tb_cmd_scheduler #(
    .TIMEOUT_WIDTH (32),
    .ERR_CNT_WIDTH (2)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_cmd_valid          (cmd_valid),
    .i_cmd_op             (cmd_op),
    .i_cmd_timeout        (cmd_timeout),
    .o_cmd_ready          (o_cmd_ready),
    .o_sel_set            (o_sel_set),
    .o_sel_wait           (o_sel_wait),
    .o_sel_check          (o_sel_check),
    .o_sel_wait_duration  (o_sel_wait_duration),
    .o_args_valid         (o_args_valid),
    .i_set_done           (set_done),
    .i_wait_done          (wait_done),
    .i_check_done         (check_done),
    .i_wait_duration_done (wd_done),
    .i_check_err          (check_err),
    .o_cmd_done           (o_cmd_done),
    .o_cmd_status         (o_cmd_status),
    .o_err_cnt            (o_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] tmo;
    int          done_at;   // BUSY cycle (1-based) of the selected done, 0 = none
    bit          err;
    bit          bogus;     // strobe a non-selected done every cycle
    int          exp_lat;   // cycles from accept edge to o_cmd_done, 0 = never
    logic [1:0]  exp_st;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outvec();
    return 32'({o_cmd_ready, o_sel_wait_duration, o_sel_check, o_sel_wait, o_sel_set,
                o_args_valid, o_cmd_done, o_cmd_status, o_err_cnt});
  endfunction

  // Transaction-level expectation: latency from the accept edge and final status.
  function automatic void model(input logic [2:0] op, input logic [31:0] tmo, input int done_at,
                                input bit err, output int lat, output logic [1:0] st);
    bit tmo_on;
    tmo_on = TMO_EN && (tmo != 0);
    if (op == 3'd0) begin
      lat = 1; st = 2'd0;
    end else if (op > 3'd4) begin
      lat = 1; st = 2'd3;
    end else if (done_at != 0 && (!tmo_on || done_at <= int'(tmo))) begin
      lat = done_at + 2; st = (op == 3'd3 && err) ? 2'd2 : 2'd0;
    end else if (tmo_on) begin
      lat = int'(tmo) + 2; st = 2'd1;
    end else begin
      lat = 0; st = 2'd0;
    end
  endfunction

  task automatic do_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, " reset outputs"}, outvec(), 32'h400);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    err_model = 0;
    last_st = 2'd0;
  endtask

  task automatic run_cmd(input string name, input logic [2:0] op, input logic [31:0] tmo,
                         input int done_at, input bit err, input bit bogus,
                         input int exp_lat, input logic [1:0] exp_st);
    logic [3:0] want, sel, other, dv;
    logic [1:0] st;
    int lat, sel_ok, sel_bad, rdy_bad, av, limit, err_seen;
    bit res_op;
    res_op  = (op >= 3'd1) && (op <= 3'd4);
    want    = res_op ? 4'(1 << (op - 3'd1)) : 4'b0;
    other   = res_op ? {want[2:0], want[3]} : 4'b0001;
    lat = 0; st = 2'd0; sel_ok = 0; sel_bad = 0; rdy_bad = 0; av = 0; err_seen = 0;
    limit = (exp_lat != 0) ? exp_lat + 4 : 100;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_timeout = tmo;
    @(negedge clk);
    check({name, " ready"}, 32'(o_cmd_ready), 32'd1);
    check({name, " held status"}, 32'(o_cmd_status), 32'(last_st));
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_timeout = $urandom;
    for (int k = 1; k <= limit; k++) begin
      dv = bogus ? other : 4'b0;
      check_err = 1'($urandom);
      if (res_op && done_at != 0 && k == done_at + 1) begin
        dv = dv | want;
        check_err = err;
      end
      {wd_done, check_done, wait_done, set_done} = dv;
      @(negedge clk);
      sel = {o_sel_wait_duration, o_sel_check, o_sel_wait, o_sel_set};
      if (want != 0 && sel == want) sel_ok++;
      else if (sel != 0) sel_bad++;
      if (o_cmd_ready) rdy_bad++;
      if (o_args_valid) av++;
      if (o_cmd_done) begin
        lat = k; st = o_cmd_status; err_seen = int'(o_err_cnt); last_done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    {wd_done, check_done, wait_done, set_done} = 4'b0;
    check_err = 1'b0;
    check({name, " latency"}, lat, exp_lat);
    check({name, " select cycles"}, sel_ok, res_op ? ((exp_lat != 0) ? exp_lat - 1 : limit) : 0);
    check({name, " wrong select"}, sel_bad, 0);
    check({name, " ready while busy"}, rdy_bad, 0);
    check({name, " args_valid count"}, av, res_op ? 1 : 0);
    if (exp_lat != 0) begin
      if (exp_st != 2'd0 && err_model < ERR_MAX) err_model++;
      last_st = exp_st;
      if (lat != 0) begin
        check({name, " status"}, 32'(st), 32'(exp_st));
        check({name, " err_cnt"}, err_seen, err_model);
      end
    end
    if (lat == 0) do_reset({name, " recover"});
  endtask

  initial begin
    int c1, lat, done_at;
    logic [1:0] st;
    logic [2:0] op;
    logic [31:0] tmo;
    bit err, bogus, saw;

    //           op    tmo  done err bog  lat                 status
    tbl[0]  = '{3'd1, 32'd0, 3, 1'b0, 1'b0, 5, 2'd0};
    tbl[1]  = '{3'd3, 32'd0, 1, 1'b1, 1'b0, 3, 2'd2};
    tbl[2]  = '{3'd3, 32'd0, 2, 1'b0, 1'b0, 4, 2'd0};
    tbl[3]  = '{3'd2, 32'd5, 0, 1'b0, 1'b0, TMO_EN ? 7 : 0, TMO_EN ? 2'd1 : 2'd0};
    tbl[4]  = '{3'd4, 32'd4, 4, 1'b0, 1'b1, 6, 2'd0};
    tbl[5]  = '{3'd6, 32'd0, 0, 1'b0, 1'b0, 1, 2'd3};
    tbl[6]  = '{3'd0, 32'd0, 0, 1'b0, 1'b0, 1, 2'd0};
    tbl[7]  = '{3'd5, 32'd9, 2, 1'b0, 1'b0, 1, 2'd3};
    tbl[8]  = '{3'd7, 32'd0, 0, 1'b0, 1'b1, 1, 2'd3};
    tbl[9]  = '{3'd2, 32'd3, 5, 1'b0, 1'b0, TMO_EN ? 5 : 7, TMO_EN ? 2'd1 : 2'd0};
    tbl[10] = '{3'd3, 32'd2, 2, 1'b1, 1'b1, 4, 2'd2};
    tbl[11] = '{3'd4, 32'd1, 0, 1'b0, 1'b0, TMO_EN ? 3 : 0, TMO_EN ? 2'd1 : 2'd0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_timeout = 32'd0;
    set_done = 1'b0; wait_done = 1'b0; check_done = 1'b0; wd_done = 1'b0; check_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("initial reset outputs", outvec(), 32'h400);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].tmo, tbl[i].done_at, tbl[i].err,
              tbl[i].bogus, tbl[i].exp_lat, tbl[i].exp_st);
    end

    // Back-to-back: illegal then NOP complete two cycles apart.
    run_cmd("b2b illegal", 3'd6, 32'd0, 0, 1'b0, 1'b0, 1, 2'd3);
    c1 = int'(last_done_cyc);
    run_cmd("b2b nop", 3'd0, 32'd0, 0, 1'b0, 1'b0, 1, 2'd0);
    check("b2b nop spacing", int'(last_done_cyc) - c1, 2);
    run_cmd("b2b set a", 3'd1, 32'd0, 1, 1'b0, 1'b0, 3, 2'd0);
    c1 = int'(last_done_cyc);
    run_cmd("b2b set b", 3'd1, 32'd0, 1, 1'b0, 1'b0, 3, 2'd0);
    check("b2b resource spacing", int'(last_done_cyc) - c1, 4);

    // Reset while BUSY: immediate return to reset values, no completion.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_timeout = 32'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("mid-busy select before reset", 32'(o_sel_set), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-busy reset outputs", outvec(), 32'h400);
    saw = 1'b0;
    repeat (3) begin @(negedge clk); saw |= o_cmd_done; end
    @(posedge clk); #1;
    rst_n = 1'b1; err_model = 0; last_st = 2'd0;
    repeat (3) begin @(negedge clk); saw |= o_cmd_done; end
    check("mid-busy no completion", 32'(saw), 32'd0);
    run_cmd("after reset", 3'd1, 32'd0, 2, 1'b0, 1'b0, 4, 2'd0);

    // Error counter saturation at its all-ones value.
    for (int i = 0; i < 5; i++) begin
      run_cmd($sformatf("sat%0d", i), 3'd5, 32'd0, 0, 1'b0, 1'b0, 1, 2'd3);
    end

    for (int n = 0; n < 60; n++) begin
      op      = 3'($urandom_range(0, 7));
      tmo     = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
      done_at = int'($urandom_range(0, 10));
      err     = 1'($urandom_range(0, 1));
      bogus   = 1'($urandom_range(0, 1));
      if (done_at == 0 && !(TMO_EN && tmo != 0)) done_at = int'($urandom_range(1, 10));
      model(op, tmo, done_at, err, lat, st);
      run_cmd($sformatf("rnd%0d", n), op, tmo, done_at, err, bogus, lat, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
